bfly_r2_stage: RTL and testbench

- Parametrised radix-2 DIF butterfly stage for the parallel-lane FFT datapath; NUM lanes processed per beat.
- First half of each frame is held in an internal delay buffer. During the second half, sum and difference outputs are produced against the buffered samples.
- Adds over the previous stage design:
  - valid-gated beat counting, so input gaps are tolerated;
  - run-time ÷2 scaling with rounding;
  - output saturation with a sticky overflow flag;
  - frame markers.

---
 rtl/bfly_r2_stage.sv | 146 ++++++++++++++
 tb/tb_bfly_r2_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_r2_stage.sv
// Radix-2 DIF butterfly stage, NUM lanes per beat.
// The first half of each frame is parked in a delay buffer. Each beat of the second half
// is combined with the matching buffered beat into a sum (dout1) and a difference (dout2).
// The per-frame /2 scaling uses round half up, and the output saturates to OUT_W bits.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   valid_in             input beat valid; the beat counter only advances on valid beats
//   din_re, din_im       NUM signed IN_W-bit samples
//   scale_en             /2 scaling request, latched on beat 0 of a frame
//   clr_ovf              synchronous clear of ovf_flag (a simultaneous set wins)
//   dout1_*, dout2_*     registered a+b and a-b, NUM signed OUT_W-bit samples
//   valid_out            output beat valid, one cycle after each COMPUTE beat
//   frame_first/last     mark the outputs of beat HALF and beat COUNT-1
//   ovf_flag             sticky saturation indicator
module bfly_r2_stage #(
   parameter int unsigned IN_W  = 10,
   parameter int unsigned OUT_W = 11,
   parameter int unsigned NUM   = 16,
   parameter int unsigned DATA  = 512,
   parameter int unsigned COUNT = DATA / NUM,
   parameter int unsigned HALF  = COUNT / 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic [NUM-1:0][IN_W-1:0]   din_re,
   input  logic [NUM-1:0][IN_W-1:0]   din_im,
   input  logic                       scale_en,
   input  logic                       clr_ovf,
   output logic [NUM-1:0][OUT_W-1:0]  dout1_re,
   output logic [NUM-1:0][OUT_W-1:0]  dout1_im,
   output logic [NUM-1:0][OUT_W-1:0]  dout2_re,
   output logic [NUM-1:0][OUT_W-1:0]  dout2_im,
   output logic                       valid_out,
   output logic                       frame_first,
   output logic                       frame_last,
   output logic                       ovf_flag
);

   localparam int unsigned CW = $clog2(COUNT);
   localparam int unsigned AW = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned FW = IN_W + 2;   // one spare bit so the rounding +1 cannot wrap

   logic [CW-1:0]            k_q;
   logic                     scale_q;
   logic [NUM-1:0][IN_W-1:0] mem_re [HALF];
   logic [NUM-1:0][IN_W-1:0] mem_im [HALF];
   logic                     fill;
   logic                     compute;
   logic [AW-1:0]            idx;

   logic [NUM-1:0][OUT_W:0]  r1_re, r1_im, r2_re, r2_im;   // {saturated, value}
   logic                     any_sat;

   // COUNT is a power of two, so the counter MSB marks the second half. The low bits give
   // slot k during FILL and slot k-HALF during COMPUTE.
   assign fill    = valid_in & ~k_q[CW-1];
   assign compute = valid_in &  k_q[CW-1];
   assign idx     = AW'(k_q);

   function automatic logic signed [IN_W:0] sx(input logic [IN_W-1:0] v);
      return {v[IN_W-1], v};
   endfunction

   // Optional round-half-up /2, then clip to OUT_W bits. MSB of the result flags saturation.
   function automatic logic [OUT_W:0] shape(input logic signed [IN_W:0] s, input logic scl);
      logic signed [FW-1:0] w;
      logic signed [FW-1:0] hi;
      logic signed [FW-1:0] lo;
      hi = FW'(2 ** (OUT_W - 1) - 1);
      lo = ~hi;
      w  = {s[IN_W], s};
      if (scl) begin
         w = (w + FW'(1)) >>> 1;
      end
      if (w > hi) begin
         return {1'b1, hi[OUT_W-1:0]};
      end else if (w < lo) begin
         return {1'b1, lo[OUT_W-1:0]};
      end
      return {1'b0, w[OUT_W-1:0]};
   endfunction

   // The delay buffer is not reset: every frame writes it before reading it.
   always_ff @(posedge clk) begin
      if (fill) begin
         mem_re[idx] <= din_re;
         mem_im[idx] <= din_im;
      end
   end

   always_comb begin
      r1_re   = '0;
      r1_im   = '0;
      r2_re   = '0;
      r2_im   = '0;
      any_sat = 1'b0;
      for (int l = 0; l < NUM; l++) begin
         r1_re[l] = shape(sx(mem_re[idx][l]) + sx(din_re[l]), scale_q);
         r1_im[l] = shape(sx(mem_im[idx][l]) + sx(din_im[l]), scale_q);
         r2_re[l] = shape(sx(mem_re[idx][l]) - sx(din_re[l]), scale_q);
         r2_im[l] = shape(sx(mem_im[idx][l]) - sx(din_im[l]), scale_q);
         any_sat  = any_sat | r1_re[l][OUT_W] | r1_im[l][OUT_W]
                            | r2_re[l][OUT_W] | r2_im[l][OUT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q         <= '0;
         scale_q     <= 1'b0;
         dout1_re    <= '0;
         dout1_im    <= '0;
         dout2_re    <= '0;
         dout2_im    <= '0;
         valid_out   <= 1'b0;
         frame_first <= 1'b0;
         frame_last  <= 1'b0;
         ovf_flag    <= 1'b0;
      end else begin
         valid_out   <= compute;
         frame_first <= compute && (k_q == CW'(HALF));
         frame_last  <= compute && (k_q == CW'(COUNT - 1));
         if (valid_in) begin
            k_q <= k_q + CW'(1);   // wraps to 0 after COUNT-1
         end
         if (valid_in && (k_q == '0)) begin
            scale_q <= scale_en;
         end
         if (compute) begin
            for (int l = 0; l < NUM; l++) begin
               dout1_re[l] <= r1_re[l][OUT_W-1:0];
               dout1_im[l] <= r1_im[l][OUT_W-1:0];
               dout2_re[l] <= r2_re[l][OUT_W-1:0];
               dout2_im[l] <= r2_im[l][OUT_W-1:0];
            end
         end
         if (compute && any_sat) begin
            ovf_flag <= 1'b1;
         end else if (clr_ovf) begin
            ovf_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bfly_r2_stage.sv
module tb_bfly_r2_stage;

   localparam int NUM   = 16;
   localparam int IN_W  = 10;
   localparam int COUNT = 32;
   localparam int HALF  = 16;

   typedef logic [767:0] wide_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid_in = 1'b0;
   logic scale_en = 1'b0;
   logic clr_ovf = 1'b0;
   logic [NUM-1:0][IN_W-1:0] din_re = '0;
   logic [NUM-1:0][IN_W-1:0] din_im = '0;

   logic [NUM-1:0][10:0] a1r, a1i, a2r, a2i;
   logic [NUM-1:0][9:0]  b1r, b1i, b2r, b2i;
   logic av, af, al, aovf, bv, bf, bl, bovf;

   // Instance A: default widths. Instance B: OUT_W=10 so saturation is reachable.
   bfly_r2_stage #(.IN_W(10), .OUT_W(11), .NUM(16), .DATA(512)) dut_a (
      .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
      .scale_en(scale_en), .clr_ovf(clr_ovf),
      .dout1_re(a1r), .dout1_im(a1i), .dout2_re(a2r), .dout2_im(a2i),
      .valid_out(av), .frame_first(af), .frame_last(al), .ovf_flag(aovf));

   bfly_r2_stage #(.IN_W(10), .OUT_W(10), .NUM(16), .DATA(512)) dut_b (
      .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
      .scale_en(scale_en), .clr_ovf(clr_ovf),
      .dout1_re(b1r), .dout1_im(b1i), .dout2_re(b2r), .dout2_im(b2i),
      .valid_out(bv), .frame_first(bf), .frame_last(bl), .ovf_flag(bovf));

   always #5 clk = ~clk;

   typedef struct {
      logic [NUM-1:0][10:0] a1r, a1i, a2r, a2i;
      logic [NUM-1:0][9:0]  b1r, b1i, b2r, b2i;
      logic                 first, last;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   nchk = 0;
   int   nerr = 0;
   int   hre[HALF][NUM];
   int   him[HALF][NUM];

   task automatic chk(input string nm, input wide_t act, input wide_t req);
      nchk++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Reference arithmetic on plain integers: floor((s+1)/2) when scaled, then clamp.
   function automatic int model(input int s, input bit scl, input int ow);
      int t, r, hi;
      r = s;
      if (scl) begin
         t = s + 1;
         r = (t >= 0) ? t / 2 : -((1 - t) / 2);
      end
      hi = (1 << (ow - 1)) - 1;
      if (r > hi) r = hi;
      if (r < -hi - 1) r = -hi - 1;
      return r;
   endfunction

   // Directed sample values: kind 0 basic ramp, kind 1 scaling/extremes, kind 2 saturation.
   function automatic int val(input int kind, input int j, input int l, input bit im);
      bit fst;
      fst = (j < HALF);
      if (kind == 0) begin
         if (l == 0) return im ? 0 : (fst ? j + 1 : 100);
         return im ? l * 11 - j * 5 : (fst ? j * l - 50 : 3 * l - j);
      end
      if (!im && l < 4) begin
         case (l)
            0: return (kind == 1) ? (fst ? 5 : 2) : 300;
            1: return (kind == 1) ? (fst ? -5 : -2) : -512;
            2: return fst ? 511 : -512;
            default: return -512;
         endcase
      end
      if (l == 0) return (kind == 1) ? (fst ? -7 : 3) : (fst ? 300 : -300);
      return ((j * 53 + l * 29 + kind * 101) % 1024) - 512;
   endfunction

   task automatic send_frame(input int kind, input bit gap, input bit scl, input int nb,
                             input bit clr_last);
      exp_t e;
      int   ar, br, ai, bi;
      for (int j = 0; j < nb; j++) begin
         if (gap) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
         end
         valid_in = 1'b1;
         scale_en = (j == 0) ? scl : !scl;
         clr_ovf  = clr_last && (j == COUNT - 1);
         for (int l = 0; l < NUM; l++) begin
            br = val(kind, j, l, 1'b0);
            bi = val(kind, j, l, 1'b1);
            din_re[l] = IN_W'(br);
            din_im[l] = IN_W'(bi);
            if (j < HALF) begin
               hre[j][l] = br;
               him[j][l] = bi;
            end else begin
               ar = hre[j-HALF][l];
               ai = him[j-HALF][l];
               e.a1r[l] = 11'(model(ar + br, scl, 11));
               e.a1i[l] = 11'(model(ai + bi, scl, 11));
               e.a2r[l] = 11'(model(ar - br, scl, 11));
               e.a2i[l] = 11'(model(ai - bi, scl, 11));
               e.b1r[l] = 10'(model(ar + br, scl, 10));
               e.b1i[l] = 10'(model(ai + bi, scl, 10));
               e.b2r[l] = 10'(model(ar - br, scl, 10));
               e.b2i[l] = 10'(model(ai - bi, scl, 10));
            end
         end
         if (j >= HALF) begin
            e.first = (j == HALF);
            e.last  = (j == COUNT - 1);
            q.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      clr_ovf  = 1'b0;
      scale_en = 1'b0;
   endtask

   // Monitor: every output beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && (av || bv)) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", wide_t'({av, bv}), wide_t'(0));
         end else begin
            mon_e = q.pop_front();
            chk("valid_pair", wide_t'({av, bv}), wide_t'(2'b11));
            chk("dut_a_data", wide_t'({a1r, a1i, a2r, a2i}),
                wide_t'({mon_e.a1r, mon_e.a1i, mon_e.a2r, mon_e.a2i}));
            chk("dut_b_data", wide_t'({b1r, b1i, b2r, b2i}),
                wide_t'({mon_e.b1r, mon_e.b1i, mon_e.b2r, mon_e.b2i}));
            chk("frame_marks", wide_t'({af, bf, al, bl}),
                wide_t'({mon_e.first, mon_e.first, mon_e.last, mon_e.last}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_a_data", wide_t'({a1r, a1i, a2r, a2i}), wide_t'(0));
      chk("reset_b_data", wide_t'({b1r, b1i, b2r, b2i}), wide_t'(0));
      chk("reset_flags", wide_t'({av, af, al, aovf, bv, bf, bl, bovf}), wide_t'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      send_frame(0, 1'b0, 1'b0, COUNT, 1'b0);   // basic
      send_frame(0, 1'b1, 1'b0, COUNT, 1'b0);   // gapped
      send_frame(1, 1'b0, 1'b1, COUNT, 1'b0);   // scaled, scale_en dropped mid-frame
      send_frame(1, 1'b0, 1'b0, COUNT, 1'b0);   // unscaled extremes, back to back
      repeat (2) @(posedge clk);
      #1;
      chk("ovf_a_extremes", wide_t'(aovf), wide_t'(0));
      chk("ovf_b_after_scaled_512", wide_t'(bovf), wide_t'(1));
      clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
      chk("ovf_b_cleared", wide_t'(bovf), wide_t'(0));

      send_frame(2, 1'b0, 1'b0, COUNT, 1'b0);   // saturation
      repeat (2) @(posedge clk);
      #1;
      chk("ovf_b_sat", wide_t'(bovf), wide_t'(1));
      chk("ovf_a_no_sat", wide_t'(aovf), wide_t'(0));
      clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
      chk("ovf_b_cleared_2", wide_t'(bovf), wide_t'(0));
      send_frame(2, 1'b0, 1'b0, COUNT, 1'b1);   // clear coincides with a saturating beat
      chk("ovf_b_set_wins", wide_t'(bovf), wide_t'(1));

      send_frame(0, 1'b0, 1'b0, 20, 1'b0);      // partial frame, then reset at beat 20
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_a_data", wide_t'({a1r, a1i, a2r, a2i}), wide_t'(0));
      chk("midrst_b_data", wide_t'({b1r, b1i, b2r, b2i}), wide_t'(0));
      chk("midrst_flags", wide_t'({av, af, al, aovf, bv, bf, bl, bovf}), wide_t'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(0, 1'b0, 1'b0, COUNT, 1'b0);

      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("queue_drain", wide_t'(q.size()), wide_t'(0));

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule
